// File: rtl/fetch_pc_pkg.sv
// Shared CPU definitions for the fetch stage: address width, reset vector,
// fetch FSM state encoding and a small PC arithmetic helper.
package fetch_pc_pkg;

    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // RUN: no redirect pending. HOLD: redirect latched, waiting for advance.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    // Sequential fetch address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] inc_pc(input logic [ADDR_W-1:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: hazard/redirect inputs from the core and the fetch
// address outputs towards instruction memory and decode.
interface fetch_pc_if
    import fetch_pc_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              stall;
    logic              imemReady;
    logic              takeBranch;
    logic [ADDR_W-1:0] braTarget;
    logic              jumpEnable;
    logic [ADDR_W-1:0] jumpTarget;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcPlus4;
    logic              imemReq;
    logic              pcMisaligned;
    logic [CNT_W-1:0]  redirectCount;

    // Core side: drives hazards and redirects, observes the fetch address.
    modport master (
        output stall, imemReady, takeBranch, braTarget, jumpEnable, jumpTarget,
        input  pc, pcPlus4, imemReq, pcMisaligned, redirectCount
    );

    // Fetch unit side.
    modport slave (
        input  stall, imemReady, takeBranch, braTarget, jumpEnable, jumpTarget,
        output pc, pcPlus4, imemReq, pcMisaligned, redirectCount
    );
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux. Purely combinational: picks the redirect target
// (pending target in HOLD, else branch over jump) and the resulting next pc.
module pc_next_sel
    import fetch_pc_pkg::*;
(
    input  fetch_state_e      state,
    input  logic              take_branch,
    input  logic [ADDR_W-1:0] bra_target,
    input  logic              jump_enable,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] pend_target,
    input  logic [ADDR_W-1:0] pc_plus4,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_target,
    output logic [ADDR_W-1:0] pc_next
);

    // Redirect source selection: a latched target overrides the live inputs.
    always_comb begin
        redir_valid  = 1'b0;
        redir_target = pend_target;
        if (state == HOLD) begin
            redir_valid  = 1'b1;
            redir_target = pend_target;
        end else if (take_branch) begin
            redir_valid  = 1'b1;
            redir_target = bra_target;
        end else if (jump_enable) begin
            redir_valid  = 1'b1;
            redir_target = jump_target;
        end
        pc_next = redir_valid ? redir_target : pc_plus4;
    end

endmodule

// File: rtl/fetch_pc.sv
// Fetch program counter. Advances on accepted fetches, applies branch/jump
// redirects one cycle after the advancing edge, and parks a redirect that
// arrives while fetch is stalled until the next advance.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                CNT_W    = 16
) (
    input  logic      clk,
    input  logic      rstn,
    fetch_pc_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q;

    logic              advance;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_target;
    logic [ADDR_W-1:0] pc_next;

    assign advance  = req_q && bus.imemReady && !bus.stall;
    assign pc_plus4 = inc_pc(pc_q);

    pc_next_sel u_sel (
        .state        (state_q),
        .take_branch  (bus.takeBranch),
        .bra_target   (bus.braTarget),
        .jump_enable  (bus.jumpEnable),
        .jump_target  (bus.jumpTarget),
        .pend_target  (pend_q),
        .pc_plus4     (pc_plus4),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .pc_next      (pc_next)
    );

    // Next-state logic: advance, park a stalled redirect, or hold.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (advance) begin
                    pc_d = pc_next;
                    if (redir_valid) cnt_d = cnt_q + CNT_ONE;
                end else if (redir_valid) begin
                    pend_d  = redir_target;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Live branch/jump inputs are ignored; the stalled producer
                // keeps re-asserting the target already latched.
                if (advance) begin
                    pc_d    = pc_next;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State, pc, pending target and counter registers; reset drops any redirect.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!rstn) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            req_q   <= 1'b1;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pcPlus4       = pc_plus4;
    assign bus.imemReq       = req_q;
    assign bus.pcMisaligned  = |pc_q[1:0];
    assign bus.redirectCount = cnt_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios plus randomized
// stimulus compared against a behavioural model of the fetch rules.
module tb_fetch_pc;
    import fetch_pc_pkg::*;

    localparam int CNT_W = 16;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: fetch address, an optional parked redirect, redirect tally.
    logic [31:0]      m_pc;
    logic             m_parked;
    logic [31:0]      m_park_target;
    logic [CNT_W-1:0] m_cnt;
    logic             m_req;

    fetch_pc_if #(.CNT_W(CNT_W)) bus ();

    fetch_pc #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc          = RST_PC;
        m_parked      = 1'b0;
        m_park_target = 32'h0;
        m_cnt         = '0;
        m_req         = 1'b0;
    endtask

    // One rising edge of the model, from the inputs currently applied.
    task automatic model_edge();
        logic accepted;
        if (!rstn) begin
            model_reset();
            return;
        end
        accepted = m_req && bus.imemReady && !bus.stall;
        if (m_parked) begin
            if (accepted) begin
                m_pc     = m_park_target;
                m_cnt    = m_cnt + 1;
                m_parked = 1'b0;
            end
        end else if (bus.takeBranch || bus.jumpEnable) begin
            if (accepted) begin
                m_pc  = bus.takeBranch ? bus.braTarget : bus.jumpTarget;
                m_cnt = m_cnt + 1;
            end else begin
                m_parked      = 1'b1;
                m_park_target = bus.takeBranch ? bus.braTarget : bus.jumpTarget;
            end
        end else if (accepted) begin
            m_pc = m_pc + 32'd4;
        end
        m_req = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] exp_p4;
        exp_p4 = m_pc + 32'd4;
        check({tag, ".pc"}, bus.pc, m_pc);
        check({tag, ".pc4"}, bus.pcPlus4, exp_p4);
        check({tag, ".req"}, {31'b0, bus.imemReq}, {31'b0, m_req});
        check({tag, ".mis"}, {31'b0, bus.pcMisaligned}, {31'b0, (m_pc[1:0] != 2'b00)});
        check({tag, ".cnt"}, {16'b0, bus.redirectCount}, {16'b0, m_cnt});
    endtask

    // Advance one clock; inputs are applied before and sampled on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        bus.stall      = 1'b0;
        bus.imemReady  = 1'b1;
        bus.takeBranch = 1'b0;
        bus.braTarget  = 32'h0;
        bus.jumpEnable = 1'b0;
        bus.jumpTarget = 32'h0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        compare_all("rst_hold");

        // Reset release and sequential fetch.
        rstn = 1'b1;
        tick("rel0");
        check("rel0_pc", bus.pc, RST_PC);
        check("rel0_req", {31'b0, bus.imemReq}, 32'd1);
        tick("rel1");
        check("rel1_pc", bus.pc, 32'hBFC0_0004);
        tick("rel2");
        check("rel2_pc", bus.pc, 32'hBFC0_0008);
        check("rel2_cnt", {16'b0, bus.redirectCount}, 32'd0);

        // Taken branch from 0x100.
        bus.jumpEnable = 1'b1; bus.jumpTarget = 32'h0000_0100;
        tick("j100");
        idle_inputs();
        bus.takeBranch = 1'b1; bus.braTarget = 32'h0000_0200;
        tick("br200");
        check("br200_pc", bus.pc, 32'h0000_0200);
        check("br200_cnt", {16'b0, bus.redirectCount}, 32'd2);

        // Stalled branch parks the target for three cycles.
        bus.braTarget = 32'h0000_0300; bus.stall = 1'b1;
        repeat (3) begin
            tick("stall");
            check("stall_pc", bus.pc, 32'h0000_0200);
        end
        bus.stall = 1'b0;
        tick("unstall");
        check("unstall_pc", bus.pc, 32'h0000_0300);
        check("unstall_cnt", {16'b0, bus.redirectCount}, 32'd3);
        idle_inputs();
        tick("after300");

        // Branch wins over jump.
        bus.takeBranch = 1'b1; bus.braTarget = 32'h0000_0400;
        bus.jumpEnable = 1'b1; bus.jumpTarget = 32'h0000_0500;
        tick("conflict");
        check("conflict_pc", bus.pc, 32'h0000_0400);
        idle_inputs();

        // Address wrap and misaligned jump target.
        bus.jumpEnable = 1'b1; bus.jumpTarget = 32'hFFFF_FFFC;
        tick("jtop");
        check("jtop_pc4", bus.pcPlus4, 32'h0);
        idle_inputs();
        tick("wrap");
        check("wrap_pc", bus.pc, 32'h0);
        bus.jumpEnable = 1'b1; bus.jumpTarget = 32'h0000_0602;
        tick("mis");
        check("mis_pc", bus.pc, 32'h0000_0602);
        check("mis_flag", {31'b0, bus.pcMisaligned}, 32'd1);
        idle_inputs();
        tick("mis_next");

        // Reset while a redirect is parked.
        bus.stall = 1'b1; bus.takeBranch = 1'b1; bus.braTarget = 32'h0000_0700;
        tick("park700");
        #2 rstn = 1'b0;
        model_reset();
        #1 check("midrst_pc", bus.pc, RST_PC);
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        tick("rrel0");
        check("rrel0_pc", bus.pc, RST_PC);
        tick("rrel1");
        check("rrel1_pc", bus.pc, 32'hBFC0_0004);
        tick("rrel2");

        // Randomized traffic, with occasional one-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.imemReady  = ($urandom_range(0, 3) != 0);
            bus.takeBranch = ($urandom_range(0, 6) == 0);
            bus.jumpEnable = ($urandom_range(0, 6) == 0);
            bus.braTarget  = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            bus.jumpTarget = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            rstn           = ($urandom_range(0, 99) != 0);
            if (!rstn) begin
                model_reset();
                #1 compare_all("rnd_rst");
            end
            tick("rnd");
            rstn = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the taken-redirect counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hazard-unit hold request; PC frozen while high.
REQ-006 SHALL have port imemReady  input  1  instruction memory accepts the current address this cycle.
REQ-007 SHALL have port takeBranch  input  1  branch comparator decision, already qualified by branch enable.
REQ-008 SHALL have port braTarget  input  32  branch destination address.
REQ-009 SHALL have port jumpEnable  input  1  unconditional jump (j/jal/jr/jalr) resolved this cycle.
REQ-010 SHALL have port jumpTarget  input  32  jump destination address.
REQ-011 SHALL have port pc  output  32  current fetch address, also driven to instruction memory.
REQ-012 SHALL have port pcPlus4  output  32  pc + 4, used for link value and delay slot.
REQ-013 SHALL have port imemReq  output  1  fetch request valid.
REQ-014 SHALL have port pcMisaligned  output  1  pc[1:0] != 0.
REQ-015 SHALL have port redirectCount  output  CNT_W  number of redirects applied to pc.

Function
REQ-016 SHALL compute pcPlus4 as pc + 32'd4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 SHALL define advance = imemReq && imemReady && !stall.
REQ-018 SHALL use two states: RUN (no pending redirect) and HOLD (redirect latched, waiting for advance).
REQ-019 SHALL, in RUN with advance, load pc with: braTarget if takeBranch; else jumpTarget if jumpEnable; else pcPlus4.
REQ-020 SHALL give takeBranch priority over jumpEnable when both are high in the same cycle.
REQ-021 SHALL, in RUN without advance and with takeBranch or jumpEnable high, latch the selected target into a pending register and enter HOLD; pc unchanged.
REQ-022 SHALL, in HOLD, ignore takeBranch/jumpEnable (the stalled branch re-asserts the same target).
REQ-023 SHALL, in HOLD with advance, load pc with the pending target and return to RUN.
REQ-024 SHALL apply a redirect exactly one cycle after the advancing edge; no bubble inserted (branch delay slot is the instruction fetched at the redirecting cycle's pc).
REQ-025 SHALL increment redirectCount by 1 on every cycle pc is loaded from a redirect (REQ-019 branch/jump case or REQ-023), wrapping at 2^CNT_W.
REQ-026 SHALL never increment redirectCount for latching into HOLD alone.
REQ-027 SHALL load misaligned targets unchanged and flag them only via pcMisaligned (combinational from pc).
REQ-028 SHALL drive imemReq high in every cycle after reset release.

Reset
REQ-029 SHALL, on rstn low, asynchronously set pc = RESET_PC, state = RUN, pending target = 0, redirectCount = 0, imemReq = 0.
REQ-030 SHALL discard any pending redirect when reset asserts mid-HOLD.
REQ-031 SHALL assert imemReq on the first rising clk edge after rstn rises, with pc = RESET_PC.

Structure
REQ-032 SHALL place RESET_PC default, state encoding (RUN, HOLD) and the 32-bit address width constant in the shared CPU package.
REQ-033 SHALL implement next-pc selection (REQ-019/020/023 priority mux) as sub-module pc_next_sel, purely combinational; state, pc and counter registers live in fetch_pc.

Verification
REQ-034 SHALL check reset: rstn low then high, imemReady=1 -> pc=32'hBFC0_0000, next cycles 32'hBFC0_0004, 32'hBFC0_0008, redirectCount=0.
REQ-035 SHALL check taken branch: pc=32'h0000_0100, takeBranch=1, braTarget=32'h0000_0200, no stall -> next pc=32'h0000_0200, redirectCount=1.
REQ-036 SHALL check stalled branch: takeBranch=1, braTarget=32'h0000_0300, stall=1 for 3 cycles -> pc held, state HOLD; stall drops -> next pc=32'h0000_0300, count incremented once.
REQ-037 SHALL check conflict: takeBranch=1 (32'h0000_0400) and jumpEnable=1 (32'h0000_0500) same cycle -> pc=32'h0000_0400.
REQ-038 SHALL check wrap and misalignment: pc=32'hFFFF_FFFC advances -> pc=0; jumpTarget=32'h0000_0602 -> pc=32'h0000_0602, pcMisaligned=1.
REQ-039 SHALL check reset mid-HOLD: enter HOLD with target 32'h0000_0700, pulse rstn low -> pc=RESET_PC after release, never 32'h0000_0700.
